// File: rtl/prog_data_mem_pkg.sv
// prog_data_mem_pkg: states, write-source select, default widths and a little-endian byte packer
package prog_data_mem_pkg;
  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;
  typedef enum logic [1:0] {SRC_CLR, SRC_LD, SRC_CPU} wsel_t;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int INS_BYTES_DEF = 2;
  localparam int PROT_LIMIT_DEF = 64;
  localparam int MAX_B = 4;
  localparam int MAX_W = 32;
  function automatic logic [MAX_B*MAX_W-1:0] pack_le(input logic [MAX_B-1:0][MAX_W-1:0] b, input int n, input int w);
    logic [MAX_B*MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_B; i++)
      for (int j = 0; j < MAX_W; j++)
        if (i < n && j < w) r[i*w+j] = b[i][j];
    return r;
  endfunction
endpackage

// File: rtl/mem_init_fsm.sv
// mem_init_fsm: CLEAR->LOAD->RUN sequencer; in clk,rst_n,ld_done; out state,ptr (clear pointer),ready,wsel (write source)
module mem_init_fsm import prog_data_mem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_done,
  output state_t            state,
  output logic [ADDR_W-1:0] ptr,
  output logic              ready,
  output wsel_t             wsel
);
  state_t nxt;
  always_ff @(posedge clk) begin
    state <= !rst_n ? CLEAR : nxt;
    ptr   <= !rst_n ? '0 : (state == CLEAR ? ptr + 1'b1 : ptr);
  end
  always_comb begin
    nxt   = (state == CLEAR && &ptr) ? LOAD : (state == LOAD && ld_done) ? RUN : state;
    ready = state == RUN;
    wsel  = state == CLEAR ? SRC_CLR : state == LOAD ? SRC_LD : SRC_CPU;
  end
endmodule

// File: rtl/prog_data_mem.sv
// prog_data_mem: unified program/data memory; in clk,rst_n,ld_*,f_req/f_addr,d_re/d_we/d_addr/d_wdata; out ready,f_ins/f_valid,d_rdata/d_rvalid,d_err
module prog_data_mem import prog_data_mem_pkg::*; #(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int INS_BYTES  = INS_BYTES_DEF,
  parameter int PROT_LIMIT = PROT_LIMIT_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ld_we,
  input  logic [ADDR_W-1:0]             ld_addr,
  input  logic [DATA_W-1:0]             ld_data,
  input  logic                          ld_done,
  output logic                          ready,
  input  logic                          f_req,
  input  logic [ADDR_W-1:0]             f_addr,
  output logic [INS_BYTES*DATA_W-1:0]   f_ins,
  output logic                          f_valid,
  input  logic                          d_re,
  input  logic                          d_we,
  input  logic [ADDR_W-1:0]             d_addr,
  input  logic [DATA_W-1:0]             d_wdata,
  output logic [DATA_W-1:0]             d_rdata,
  output logic                          d_rvalid,
  output logic                          d_err
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int INS_W = INS_BYTES*DATA_W;
  state_t state;
  wsel_t wsel;
  logic [ADDR_W-1:0] ptr, waddr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] wdata;
  logic [MAX_B-1:0][MAX_W-1:0] fb;
  logic run, prot, we;
  mem_init_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk(clk),
    .rst_n(rst_n),
    .ld_done(ld_done),
    .state(state),
    .ptr(ptr),
    .ready(ready),
    .wsel(wsel)
  );
  always_comb begin
    run   = state == RUN;
    prot  = 32'(d_addr) < PROT_LIMIT;
    we    = rst_n && (wsel == SRC_CLR || (wsel == SRC_LD && ld_we) || (run && d_we && !prot));
    waddr = wsel == SRC_CLR ? ptr : wsel == SRC_LD ? ld_addr : d_addr;
    wdata = wsel == SRC_CLR ? '0 : wsel == SRC_LD ? ld_data : d_wdata;
    fb    = '0;
    for (int i = 0; i < INS_BYTES; i++) fb[i][DATA_W-1:0] = mem[f_addr + ADDR_W'(i)];
  end
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_valid  <= 1'b0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      f_ins    <= '0;
      d_rdata  <= '0;
    end else begin
      f_valid  <= run && f_req;
      d_rvalid <= run && d_re && !d_we;
      d_err    <= d_we && (state == LOAD || (run && prot));
      if (run && f_req) f_ins <= INS_W'(pack_le(fb, INS_BYTES, DATA_W));
      if (run && d_re && !d_we) d_rdata <= mem[d_addr];
    end
  end
endmodule

// File: tb/tb_prog_data_mem.sv
// tb_prog_data_mem: randomized self-checking bench against a phase/array reference model
module tb_prog_data_mem;
  logic clk = 0, rst_n = 0, ld_we = 0, ld_done = 0, f_req = 0, d_re = 0, d_we = 0;
  logic [7:0] ld_addr = 0, ld_data = 0, f_addr = 0, d_addr = 0, d_wdata = 0;
  logic [7:0] d_rdata;
  logic [15:0] f_ins;
  logic ready, f_valid, d_rvalid, d_err;
  int total = 0, bad = 0, ph = 0, clr = 0, n = 0;
  logic [7:0] m [256];
  logic [15:0] e_fi = 0;
  logic [7:0] e_rd = 0;
  logic e_fv = 0, e_rv = 0, e_err = 0;
  prog_data_mem dut (
    .clk(clk), .rst_n(rst_n),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
    .ready(ready),
    .f_req(f_req), .f_addr(f_addr), .f_ins(f_ins), .f_valid(f_valid),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_err(d_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic quiet();
    ld_we = 0; ld_done = 0; f_req = 0; d_re = 0; d_we = 0;
  endtask
  task automatic step();
    logic [7:0] a1;
    if (!rst_n) begin
      ph = 0; clr = 0; e_fv = 0; e_rv = 0; e_err = 0; e_fi = 0; e_rd = 0;
    end else begin
      a1 = f_addr + 8'd1;
      e_fv = ph == 2 && f_req;
      if (e_fv) e_fi = {m[a1], m[f_addr]};
      e_rv = ph == 2 && d_re && !d_we;
      if (e_rv) e_rd = m[d_addr];
      e_err = d_we && (ph == 1 || (ph == 2 && d_addr < 64));
      if (ph == 0) begin
        m[clr] = 8'h00;
        if (clr == 255) ph = 1;
        clr++;
      end else if (ph == 1) begin
        if (ld_we) m[ld_addr] = ld_data;
        if (ld_done) ph = 2;
      end else if (d_we && d_addr >= 64) m[d_addr] = d_wdata;
    end
    @(posedge clk); #1;
    chk("ready", ready, ph == 2);
    chk("f_valid", f_valid, e_fv);
    chk("f_ins", f_ins, e_fi);
    chk("d_rvalid", d_rvalid, e_rv);
    chk("d_rdata", d_rdata, e_rd);
    chk("d_err", d_err, e_err);
  endtask
  task automatic do_reset();
    quiet(); rst_n = 0; step(); rst_n = 1;
  endtask
  task automatic ld(input logic [7:0] a, input logic [7:0] d, input logic done);
    ld_we = 1; ld_addr = a; ld_data = d; ld_done = done; step(); quiet();
  endtask
  task automatic fetch(input logic [7:0] a);
    f_req = 1; f_addr = a; step(); quiet();
  endtask
  task automatic dwr(input logic [7:0] a, input logic [7:0] d);
    d_we = 1; d_addr = a; d_wdata = d; step(); quiet();
  endtask
  task automatic drd(input logic [7:0] a);
    d_re = 1; d_addr = a; step(); quiet();
  endtask
  initial begin
    do_reset();
    chk("rst_ready", ready, 0);
    ld_done = 1; n = 0;
    do begin step(); n++; end while (!ready && n < 400);
    quiet();
    chk("rdy_lat", n, 257);
    fetch(8'($urandom));
    chk("idle_fetch", f_ins, 16'h0000);
    do_reset();
    repeat (256) step();
    ld(8'h10, 8'h5A, 0); ld(8'hFF, 8'h12, 0); ld(8'h00, 8'h34, 0); ld(8'h80, 8'h77, 0);
    d_we = 1; d_addr = 8'h90; d_wdata = 8'h55; step(); quiet();
    chk("ld_derr", d_err, 1);
    ld(8'h04, 8'h70, 0); ld(8'h05, 8'h00, 1);
    chk("run_ready", ready, 1);
    fetch(8'h04);
    chk("fetch4_v", f_valid, 1);
    chk("fetch4", f_ins, 16'h0070);
    fetch(8'hFF);
    chk("wrap", f_ins, 16'h3412);
    dwr(8'hFF, 8'h0F); drd(8'hFF);
    chk("rd_ff_v", d_rvalid, 1);
    chk("rd_ff", d_rdata, 8'h0F);
    dwr(8'h10, 8'hAA);
    chk("err10", d_err, 1);
    step();
    chk("err10_pulse", d_err, 0);
    fetch(8'h10);
    chk("fetch10", f_ins, 16'h005A);
    f_req = 1; f_addr = 8'h80; d_we = 1; d_addr = 8'h80; d_wdata = 8'h99; step(); quiet();
    chk("old80", f_ins, 16'h0077);
    fetch(8'h80);
    chk("new80", f_ins, 16'h0099);
    repeat (400) begin
      f_req = 1'($urandom); f_addr = 8'($urandom);
      d_re = 1'($urandom); d_we = 1'($urandom); d_addr = 8'($urandom); d_wdata = 8'($urandom);
      ld_we = 1'($urandom); ld_addr = 8'($urandom); ld_data = 8'($urandom);
      step();
    end
    quiet();
    do_reset();
    repeat (256) step();
    ld(8'h20, 8'hAB, 0); ld(8'hC0, 8'hCD, 0); ld(8'hFF, 8'hEE, 0);
    do_reset();
    repeat (256) step();
    ld_done = 1; step(); quiet();
    fetch(8'h20);
    chk("clr20", f_ins, 16'h0000);
    fetch(8'hC0);
    chk("clrC0", f_ins, 16'h0000);
    fetch(8'hFF);
    chk("clrFF", f_ins, 16'h0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
